// File: rtl/wishbone_dcm_monitor.sv
// WISHBONE register slave exposing firmware ID/version bytes plus lock monitoring,
// sticky error flags, lock-loss counters and a timed reset pulse for up to four DCMs.
module wishbone_dcm_monitor #(
    parameter logic [31:0] ID           = "WBID",
    parameter logic [3:0]  VER_BOARD    = 4'd0,
    parameter logic [3:0]  VER_MONTH    = 4'd0,
    parameter logic [7:0]  VER_DAY      = 8'd0,
    parameter logic [3:0]  VER_MAJOR    = 4'd0,
    parameter logic [3:0]  VER_MINOR    = 4'd0,
    parameter logic [7:0]  VER_REV      = 8'd0,
    parameter int          NUM_DCM      = 1,
    parameter int          RESET_CYCLES = 100,
    parameter int          LOCK_TIMEOUT = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cyc_i,
    input  logic                   stb_i,
    input  logic                   wr_i,
    input  logic [15:0]            adr_i,
    input  logic [7:0]             dat_i,
    output logic [7:0]             dat_o,
    output logic                   ack_o,
    output logic                   err_o,
    output logic                   rty_o,
    input  logic [NUM_DCM-1:0]     dcm_locked_i,
    input  logic [3*NUM_DCM-1:0]   dcm_status_i,
    output logic [NUM_DCM-1:0]     dcm_reset_o
);

    localparam int PCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam int TCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(RESET_CYCLES - 1);
    localparam logic [TCW-1:0] WAIT_LAST  = TCW'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] VERSION = {VER_BOARD, VER_MONTH, VER_DAY, VER_MAJOR, VER_MINOR, VER_REV};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE     = 2'd1,
        WAIT_LOCK = 2'd2
    } state_t;

    logic       wrStb;
    logic [7:0] statRd [4];
    logic [7:0] llRd   [4];
    logic       unusedBits;

    assign wrStb      = cyc_i & stb_i & wr_i;
    assign ack_o      = cyc_i & stb_i;
    assign err_o      = 1'b0;
    assign rty_o      = 1'b0;
    assign unusedBits = ^{adr_i[15:5], dat_i[3:0]};

    for (genvar g = 0; g < 4; g++) begin : gCh
        if (g < NUM_DCM) begin : gOn
            logic           lockMeta_q, lockSync_q, lockPrev_q;
            logic [2:0]     statMeta_q, statSync_q;
            logic           lossFlag_q, lossFlag_d;
            logic           errFlag_q, errFlag_d;
            logic           toFlag_q, toFlag_d;
            logic [7:0]     llCnt_q, llCnt_d;
            state_t         state_q, state_d;
            logic [PCW-1:0] pulseCnt_q, pulseCnt_d;
            logic [TCW-1:0] waitCnt_q, waitCnt_d;
            logic           dcmReset_q;
            logic           statWr, llWr, lossEvent;

            assign statWr    = wrStb && (adr_i[4:0] == 5'(8 + g));
            assign llWr      = wrStb && (adr_i[4:0] == 5'(12 + g));
            // Lock drops are only events when we did not cause them with a reset pulse.
            assign lossEvent = lockPrev_q && !lockSync_q && (state_q == IDLE);

            // Sets are applied after clears so a coincident event is never lost.
            always_comb begin
                state_d    = state_q;
                pulseCnt_d = pulseCnt_q;
                waitCnt_d  = waitCnt_q;
                lossFlag_d = lossFlag_q;
                errFlag_d  = errFlag_q;
                toFlag_d   = toFlag_q;
                llCnt_d    = llCnt_q;

                if (statWr && dat_i[5]) lossFlag_d = 1'b0;
                if (statWr && dat_i[6]) errFlag_d  = 1'b0;
                if (statWr && dat_i[4]) toFlag_d   = 1'b0;
                if (llWr)               llCnt_d    = 8'd0;

                if (lossEvent) begin
                    lossFlag_d = 1'b1;
                    if (llWr)
                        llCnt_d = 8'd1;
                    else if (llCnt_q != 8'hFF)
                        llCnt_d = llCnt_q + 8'd1;
                end
                if (statSync_q != 3'd0) errFlag_d = 1'b1;

                case (state_q)
                    IDLE: begin
                        if (statWr && dat_i[7]) begin
                            state_d    = PULSE;
                            pulseCnt_d = '0;
                        end
                    end
                    PULSE: begin
                        if (pulseCnt_q == PULSE_LAST) begin
                            state_d   = WAIT_LOCK;
                            waitCnt_d = '0;
                        end else begin
                            pulseCnt_d = pulseCnt_q + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lockSync_q) begin
                            state_d = IDLE;
                        end else if (waitCnt_q == WAIT_LAST) begin
                            state_d  = IDLE;
                            toFlag_d = 1'b1;
                        end else begin
                            waitCnt_d = waitCnt_q + 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    lockMeta_q <= 1'b0;
                    lockSync_q <= 1'b0;
                    lockPrev_q <= 1'b0;
                    statMeta_q <= 3'd0;
                    statSync_q <= 3'd0;
                    lossFlag_q <= 1'b0;
                    errFlag_q  <= 1'b0;
                    toFlag_q   <= 1'b0;
                    llCnt_q    <= 8'd0;
                    state_q    <= IDLE;
                    pulseCnt_q <= '0;
                    waitCnt_q  <= '0;
                    dcmReset_q <= 1'b0;
                end else begin
                    lockMeta_q <= dcm_locked_i[g];
                    lockSync_q <= lockMeta_q;
                    lockPrev_q <= lockSync_q;
                    statMeta_q <= dcm_status_i[3*g +: 3];
                    statSync_q <= statMeta_q;
                    lossFlag_q <= lossFlag_d;
                    errFlag_q  <= errFlag_d;
                    toFlag_q   <= toFlag_d;
                    llCnt_q    <= llCnt_d;
                    state_q    <= state_d;
                    pulseCnt_q <= pulseCnt_d;
                    waitCnt_q  <= waitCnt_d;
                    dcmReset_q <= (state_d == PULSE);
                end
            end

            assign statRd[g]      = {toFlag_q, errFlag_q, lossFlag_q, (state_q != IDLE),
                                     statSync_q, lockSync_q};
            assign llRd[g]        = llCnt_q;
            assign dcm_reset_o[g] = dcmReset_q;
        end else begin : gOff
            assign statRd[g] = 8'd0;
            assign llRd[g]   = 8'd0;
        end
    end

    always_comb begin
        dat_o = 8'd0;
        case (adr_i[4:2])
            3'd0:    dat_o = ID[{adr_i[1:0], 3'b000} +: 8];
            3'd1:    dat_o = VERSION[{adr_i[1:0], 3'b000} +: 8];
            3'd2:    dat_o = statRd[adr_i[1:0]];
            3'd3:    dat_o = llRd[adr_i[1:0]];
            default: dat_o = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_wishbone_dcm_monitor.sv
// Directed bench for wishbone_dcm_monitor with two channels, 100-cycle pulses and a 50-cycle relock window.
module tb_wishbone_dcm_monitor;

    logic        clk = 1'b0;
    logic        rstN;
    logic        cyc, stb, wr;
    logic [15:0] adr;
    logic [7:0]  datIn;
    logic [7:0]  datOut;
    logic        ack, err, rty;
    logic [1:0]  locked;
    logic [5:0]  status;
    logic [1:0]  dcmReset;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wishbone_dcm_monitor #(
        .ID(32'h57424944),
        .VER_BOARD(4'hA), .VER_MONTH(4'h3), .VER_DAY(8'h15),
        .VER_MAJOR(4'h2), .VER_MINOR(4'h7), .VER_REV(8'h09),
        .NUM_DCM(2), .RESET_CYCLES(100), .LOCK_TIMEOUT(50)
    ) dut (
        .clk_i(clk), .rst_n_i(rstN),
        .cyc_i(cyc), .stb_i(stb), .wr_i(wr),
        .adr_i(adr), .dat_i(datIn), .dat_o(datOut),
        .ack_o(ack), .err_o(err), .rty_o(rty),
        .dcm_locked_i(locked), .dcm_status_i(status), .dcm_reset_o(dcmReset)
    );

    // Reads are combinational, so they are sampled mid-cycle without crossing a clock edge.
    task automatic wbRead(input logic [4:0] a, output logic [7:0] d, output logic ackSeen);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; wr = 1'b0; adr = {11'd0, a};
        #1;
        d = datOut;
        ackSeen = ack;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wbWrite(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; wr = 1'b1; adr = {11'd0, a}; datIn = d;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic       a;
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL rst_stat0: got %02h expected 00", d); end
        checks++;
        if (dcmReset !== 2'b00) begin errors++; $display("[TB] FAIL rst_dcmreset: got %b expected 00", dcmReset); end
        @(negedge clk);
        rstN = 1'b1;
        repeat (4) @(posedge clk);
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL rst_stat0_locked: got %02h expected 01", d); end
        wbRead(5'h09, d, a);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL rst_stat1_locked: got %02h expected 01", d); end
        wbRead(5'h0C, d, a);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL rst_llcnt0: got %02h expected 00", d); end
    endtask

    task automatic test_id;
        logic [7:0] expBytes [8];
        logic [7:0] d;
        logic       a;
        expBytes = '{8'h44, 8'h49, 8'h42, 8'h57, 8'h09, 8'h27, 8'h15, 8'hA3};
        for (int i = 0; i < 8; i++) begin
            wbRead(5'(i), d, a);
            checks++;
            if (d !== expBytes[i]) begin
                errors++; $display("[TB] FAIL id_byte%0d: got %02h expected %02h", i, d, expBytes[i]);
            end
            checks++;
            if (a !== 1'b1) begin errors++; $display("[TB] FAIL id_ack%0d: got %b expected 1", i, a); end
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL ack_nostb: got %b expected 0", ack); end
        checks++;
        if ({err, rty} !== 2'b00) begin errors++; $display("[TB] FAIL err_rty: got %b expected 00", {err, rty}); end
        cyc = 1'b0;
    endtask

    task automatic test_pulse;
        logic [7:0] d;
        logic       a;
        int         cnt;
        wbWrite(5'h09, 8'h80);
        checks++;
        if (dcmReset !== 2'b10) begin errors++; $display("[TB] FAIL pulse_start: got %b expected 10", dcmReset); end
        locked[1] = 1'b0;
        cnt = 1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (dcmReset[1]) cnt++;
            else break;
        end
        checks++;
        if (cnt !== 100) begin errors++; $display("[TB] FAIL pulse_len: got %0d expected 100", cnt); end
        repeat (10) @(posedge clk);
        wbRead(5'h09, d, a);
        checks++;
        if (d !== 8'h10) begin errors++; $display("[TB] FAIL pulse_waitlock: got %02h expected 10", d); end
        locked[1] = 1'b1;
        repeat (3) @(posedge clk);
        wbRead(5'h09, d, a);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL pulse_relock: got %02h expected 01", d); end
        wbRead(5'h0D, d, a);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL pulse_llcnt1: got %02h expected 00", d); end
    endtask

    task automatic test_saturate;
        logic [7:0] d;
        logic       a;
        for (int i = 0; i < 5; i++) begin
            locked[0] = 1'b0; repeat (3) @(posedge clk);
            locked[0] = 1'b1; repeat (3) @(posedge clk);
        end
        wbRead(5'h0C, d, a);
        checks++;
        if (d !== 8'd5) begin errors++; $display("[TB] FAIL llcnt_five: got %02h expected 05", d); end
        for (int i = 0; i < 295; i++) begin
            locked[0] = 1'b0; repeat (3) @(posedge clk);
            locked[0] = 1'b1; repeat (3) @(posedge clk);
        end
        wbRead(5'h0C, d, a);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("[TB] FAIL llcnt_sat: got %02h expected ff", d); end
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h21) begin errors++; $display("[TB] FAIL loss_flag: got %02h expected 21", d); end
        wbRead(5'h0D, d, a);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL llcnt1_indep: got %02h expected 00", d); end
        wbWrite(5'h08, 8'h20);
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL loss_clear: got %02h expected 01", d); end
        wbWrite(5'h0C, 8'h00);
        wbRead(5'h0C, d, a);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL llcnt_clear: got %02h expected 00", d); end
    endtask

    task automatic test_timeout;
        logic [7:0] d;
        logic       a;
        int         cnt;
        wbWrite(5'h08, 8'h80);
        checks++;
        if (dcmReset !== 2'b01) begin errors++; $display("[TB] FAIL to_start: got %b expected 01", dcmReset); end
        locked[0] = 1'b0;
        cnt = 1;
        for (int k = 0; k < 300; k++) begin
            if (k == 20) begin
                cyc = 1'b1; stb = 1'b1; wr = 1'b1; adr = 16'h0008; datIn = 8'h80;
            end
            @(posedge clk);
            #1;
            cyc = 1'b0; stb = 1'b0; wr = 1'b0;
            if (dcmReset[0]) cnt++;
            else break;
        end
        checks++;
        if (cnt !== 100) begin errors++; $display("[TB] FAIL to_pulse_len: got %0d expected 100", cnt); end
        repeat (48) @(posedge clk);
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h10) begin errors++; $display("[TB] FAIL to_still_busy: got %02h expected 10", d); end
        repeat (2) @(posedge clk);
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h80) begin errors++; $display("[TB] FAIL to_flag: got %02h expected 80", d); end
        wbRead(5'h0C, d, a);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL to_no_count: got %02h expected 00", d); end
        locked[0] = 1'b1;
        repeat (3) @(posedge clk);
        wbWrite(5'h08, 8'h10);
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL to_clear: got %02h expected 01", d); end
    endtask

    task automatic test_set_clear;
        logic [7:0] d;
        logic       a;
        for (int i = 0; i < 2; i++) begin
            locked[0] = 1'b0; repeat (3) @(posedge clk);
            locked[0] = 1'b1; repeat (3) @(posedge clk);
        end
        wbRead(5'h0C, d, a);
        checks++;
        if (d !== 8'd2) begin errors++; $display("[TB] FAIL sc_pre: got %02h expected 02", d); end
        // The drop reaches the event logic two edges later, so the clear lands on the increment edge.
        @(negedge clk);
        locked[0] = 1'b0;
        repeat (2) @(posedge clk);
        wbWrite(5'h0C, 8'h00);
        wbRead(5'h0C, d, a);
        checks++;
        if (d !== 8'd1) begin errors++; $display("[TB] FAIL sc_llcnt: got %02h expected 01", d); end
        locked[0] = 1'b1;
        repeat (3) @(posedge clk);
        wbWrite(5'h08, 8'h20);
        @(negedge clk);
        status[2:0] = 3'b010;
        @(negedge clk);
        status[2:0] = 3'b000;
        repeat (4) @(posedge clk);
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h41) begin errors++; $display("[TB] FAIL err_sticky: got %02h expected 41", d); end
        repeat (10) @(posedge clk);
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h41) begin errors++; $display("[TB] FAIL err_hold: got %02h expected 41", d); end
        wbWrite(5'h08, 8'h40);
        wbRead(5'h08, d, a);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL err_clear: got %02h expected 01", d); end
        status[5:3] = 3'b101;
        repeat (4) @(posedge clk);
        wbRead(5'h09, d, a);
        checks++;
        if (d !== 8'h4B) begin errors++; $display("[TB] FAIL status_bits: got %02h expected 4b", d); end
        status[5:3] = 3'b000;
        repeat (3) @(posedge clk);
        wbWrite(5'h09, 8'h40);
        wbRead(5'h09, d, a);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL status_clear: got %02h expected 01", d); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic       a;
        wbWrite(5'h0C, 8'h00);
        locked[0] = 1'b0; repeat (3) @(posedge clk);
        locked[0] = 1'b1; repeat (3) @(posedge clk);
        wbRead(5'h0C, d, a);
        checks++;
        if (d !== 8'd1) begin errors++; $display("[TB] FAIL mid_pre_llcnt: got %02h expected 01", d); end
        wbWrite(5'h09, 8'h80);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (dcmReset !== 2'b10) begin errors++; $display("[TB] FAIL mid_pulsing: got %b expected 10", dcmReset); end
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (dcmReset !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_out: got %b expected 00", dcmReset); end
        for (int i = 8; i < 16; i++) begin
            wbRead(5'(i), d, a);
            checks++;
            if (d !== 8'h00) begin errors++; $display("[TB] FAIL mid_reg%02h: got %02h expected 00", i, d); end
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (4) @(posedge clk);
        wbRead(5'h09, d, a);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL mid_after_stat1: got %02h expected 01", d); end
        wbWrite(5'h0B, 8'h80);
        checks++;
        if (dcmReset !== 2'b00) begin errors++; $display("[TB] FAIL ch3_write: got %b expected 00", dcmReset); end
        wbRead(5'h0B, d, a);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL ch3_read: got %02h expected 00", d); end
        wbRead(5'h13, d, a);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL hi_read: got %02h expected 00", d); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0; cyc = 1'b0; stb = 1'b0; wr = 1'b0;
        adr = 16'd0; datIn = 8'd0; locked = 2'b11; status = 6'd0;
        repeat (3) @(posedge clk);
        test_reset;
        test_id;
        test_pulse;
        test_saturate;
        test_timeout;
        test_set_clear;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
